// File: rtl/triangle_bbox_scanner.sv
// Walks a triangle's screen-clipped bounding box in raster order, feeding candidates to the fill
// stage and re-aligning its coverage results. Optional macro TRI_SCAN_STATS_EN adds frag_count.
//
// state | meaning
// IDLE  | tri_ready high, waiting for a triangle
// SETUP | bounding box computed and clipped; empty boxes finish here
// SCAN  | one candidate pixel per cycle to fill
// DRAIN | waiting FILL_LATENCY cycles for the last fill results
module triangle_bbox_scanner #(
  parameter int SCREEN_W     = 1280,
  parameter int SCREEN_H     = 720,
  parameter int FILL_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0][1:0][11:0]   tri_in,
  input  logic                    tri_valid,
  output logic                    tri_ready,
  output logic [11:0]             fill_hcount,
  output logic [11:0]             fill_vcount,
  output logic [2:0][1:0][11:0]   fill_triangle,
  output logic                    fill_valid_out,
  input  logic                    fill_valid_in,
  input  logic                    fill_within,
  output logic                    pix_valid,
  output logic [11:0]             pix_x,
  output logic [11:0]             pix_y,
  output logic                    busy,
  output logic                    done,
  output logic [23:0]             frag_count
);

  localparam logic [11:0] X_LAST = 12'(SCREEN_W - 1);
  localparam logic [11:0] Y_LAST = 12'(SCREEN_H - 1);
  localparam int          CW     = (FILL_LATENCY < 2) ? 1 : $clog2(FILL_LATENCY);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;

  state_t          state;
  logic [11:0]     x, y, xmin_r, xmax_r, ymax_r;
  logic [CW-1:0]   drain_cnt;
  logic [11:0]     bx_min, bx_max, by_min, by_max;

  function automatic logic [11:0] min3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [11:0] max3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always_comb begin
    bx_min = min3(fill_triangle[0][0], fill_triangle[1][0], fill_triangle[2][0]);
    by_min = min3(fill_triangle[0][1], fill_triangle[1][1], fill_triangle[2][1]);
    bx_max = max3(fill_triangle[0][0], fill_triangle[1][0], fill_triangle[2][0]);
    by_max = max3(fill_triangle[0][1], fill_triangle[1][1], fill_triangle[2][1]);
    if (bx_max > X_LAST) bx_max = X_LAST;
    if (by_max > Y_LAST) by_max = Y_LAST;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      tri_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      fill_valid_out <= 1'b0;
      fill_triangle  <= '0;
      x              <= '0;
      y              <= '0;
      xmin_r         <= '0;
      xmax_r         <= '0;
      ymax_r         <= '0;
      drain_cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (tri_valid) begin
            fill_triangle <= tri_in;
            tri_ready     <= 1'b0;
            busy          <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (bx_min > X_LAST || by_min > Y_LAST) begin
            tri_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            x              <= bx_min;
            y              <= by_min;
            xmin_r         <= bx_min;
            xmax_r         <= bx_max;
            ymax_r         <= by_max;
            fill_valid_out <= 1'b1;
            state          <= SCAN;
          end
        end
        SCAN: begin
          if (x == xmax_r && y == ymax_r) begin
            fill_valid_out <= 1'b0;
            drain_cnt      <= CW'(FILL_LATENCY - 1);
            done           <= (FILL_LATENCY == 1);
            state          <= DRAIN;
          end else if (x == xmax_r) begin
            x <= xmin_r;
            y <= y + 12'd1;
          end else begin
            x <= x + 12'd1;
          end
        end
        DRAIN: begin
          // done is raised entering the final drain cycle so it lines up with the last result
          if (drain_cnt == '0) begin
            tri_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
            done      <= (drain_cnt == CW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fill_hcount = x;
  assign fill_vcount = y;

  logic [FILL_LATENCY-1:0]        dl_vld;
  logic [FILL_LATENCY-1:0][11:0]  dl_x, dl_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_vld <= '0;
      dl_x   <= '0;
      dl_y   <= '0;
    end else begin
      dl_vld[0] <= fill_valid_out;
      dl_x[0]   <= x;
      dl_y[0]   <= y;
      for (int i = 1; i < FILL_LATENCY; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_x[i]   <= dl_x[i-1];
        dl_y[i]   <= dl_y[i-1];
      end
    end
  end

  // the valid tap masks stale fill results from a triangle abandoned by reset
  assign pix_valid = fill_valid_in && fill_within && dl_vld[FILL_LATENCY-1];
  assign pix_x     = dl_x[FILL_LATENCY-1];
  assign pix_y     = dl_y[FILL_LATENCY-1];

`ifdef TRI_SCAN_STATS_EN
  logic [23:0] frag_cnt, frag_hold, frag_next;

  always_comb begin
    frag_next = frag_cnt;
    if (pix_valid && frag_cnt != '1) frag_next = frag_cnt + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frag_cnt  <= '0;
      frag_hold <= '0;
    end else begin
      if (state == IDLE && tri_valid) frag_cnt <= '0;
      else                            frag_cnt <= frag_next;
      if (done) frag_hold <= frag_next;
    end
  end

  assign frag_count = done ? frag_next : frag_hold;
`else
  assign frag_count = '0;
`endif

endmodule

// File: tb/tb_triangle_bbox_scanner.sv
// Scoreboard bench for triangle_bbox_scanner with a behavioural fill stage model.
module tb_triangle_bbox_scanner;

  typedef logic [2:0][1:0][11:0] tri_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  tri_t        tri_in = '0;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [11:0] fill_hcount, fill_vcount;
  tri_t        fill_triangle;
  logic        fill_valid_out, fill_valid_in, fill_within;
  logic        pix_valid;
  logic [11:0] pix_x, pix_y;
  logic        busy, done;
  logic [23:0] frag_count;

  triangle_bbox_scanner dut (
    .clk(clk), .rst_n(rst_n), .tri_in(tri_in), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .fill_hcount(fill_hcount), .fill_vcount(fill_vcount), .fill_triangle(fill_triangle),
    .fill_valid_out(fill_valid_out), .fill_valid_in(fill_valid_in), .fill_within(fill_within),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .done(done),
    .frag_count(frag_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name, input logic [79:0] act);
    checks++;
    failures++;
    $display("FAIL %s got=%0h expected=none (cycle %0d)", name, act, cyc);
  endtask

  // inclusive edge-function coverage test, either winding
  function automatic logic covers(input tri_t t, input int px, input int py);
    int x0, y0, x1, y1, x2, y2, e0, e1, e2;
    x0 = int'(t[0][0]); y0 = int'(t[0][1]);
    x1 = int'(t[1][0]); y1 = int'(t[1][1]);
    x2 = int'(t[2][0]); y2 = int'(t[2][1]);
    e0 = (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
    e1 = (x2 - x1) * (py - y1) - (y2 - y1) * (px - x1);
    e2 = (x0 - x2) * (py - y2) - (y0 - y2) * (px - x2);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  // fill stage model: fixed 3-cycle pipeline
  logic [2:0] fm_v = '0;
  logic [2:0] fm_w = '0;
  always @(posedge clk) begin
    fm_v <= {fm_v[1:0], fill_valid_out};
    fm_w <= {fm_w[1:0], covers(fill_triangle, int'(fill_hcount), int'(fill_vcount))};
  end
  assign fill_valid_in = fm_v[2];
  assign fill_within   = fm_w[2];

  logic [23:0] cand_q[$];
  logic [23:0] pix_q[$];
  tri_t        cur_tri = '0;
  bit          outstanding = 0;
  bit          frag_pend = 0;
  bit          last_empty = 1;
  int          exp_done_cyc = 0;
  int          last_done_cyc = -10;
  int          exp_frag = 0;
  int          obs_cand = 0;
  int          obs_pix = 0;
  logic [23:0] first_c = '0;
  logic [23:0] last_c = '0;

  task automatic build_model(input tri_t t);
    int xs[3], ys[3], xmin, xmax, ymin, ymax;
    for (int i = 0; i < 3; i++) begin
      xs[i] = int'(t[i][0]);
      ys[i] = int'(t[i][1]);
    end
    xmin = xs[0]; xmax = xs[0]; ymin = ys[0]; ymax = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < xmin) xmin = xs[i];
      if (xs[i] > xmax) xmax = xs[i];
      if (ys[i] < ymin) ymin = ys[i];
      if (ys[i] > ymax) ymax = ys[i];
    end
    if (xmax > 1279) xmax = 1279;
    if (ymax > 719) ymax = 719;
    cand_q.delete();
    pix_q.delete();
    if (xmin <= 1279 && ymin <= 719) begin
      for (int yy = ymin; yy <= ymax; yy++)
        for (int xx = xmin; xx <= xmax; xx++) begin
          cand_q.push_back({12'(xx), 12'(yy)});
          if (covers(t, xx, yy)) pix_q.push_back({12'(xx), 12'(yy)});
        end
    end
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst_n) begin
      cand_q.delete();
      pix_q.delete();
      outstanding = 0;
      frag_pend = 0;
    end else begin
      if (frag_pend) begin
        chk("frag_count", frag_count, exp_frag);
        frag_pend = 0;
      end
      if (fill_valid_out) begin
        if (cand_q.size() == 0) bad("cand_extra", {fill_hcount, fill_vcount});
        else begin
          e = cand_q.pop_front();
          chk("cand_xy", {fill_hcount, fill_vcount}, e);
        end
        chk("fill_triangle", fill_triangle, cur_tri);
        if (obs_cand == 0) first_c = {fill_hcount, fill_vcount};
        last_c = {fill_hcount, fill_vcount};
        obs_cand++;
      end
      if (pix_valid) begin
        if (pix_q.size() == 0) bad("pix_extra", {pix_x, pix_y});
        else begin
          e = pix_q.pop_front();
          chk("pix_xy", {pix_x, pix_y}, e);
        end
        obs_pix++;
      end
      if (done) begin
        if (!outstanding) bad("done_unexpected", done);
        else begin
          chk("done_cycle", cyc, exp_done_cyc);
          chk("cand_left", cand_q.size(), 0);
          chk("pix_left", pix_q.size(), 0);
          outstanding = 0;
          frag_pend = 1;
          last_done_cyc = cyc;
        end
      end
      if (tri_valid && tri_ready) begin
        chk("accept_idle", outstanding, 0);
        chk("accept_after_done", (cyc > last_done_cyc) || last_empty, 1);
        cur_tri = tri_in;
        build_model(tri_in);
        last_empty = (cand_q.size() == 0);
        exp_done_cyc = last_empty ? cyc + 2 : cyc + cand_q.size() + 4;
`ifdef TRI_SCAN_STATS_EN
        exp_frag = pix_q.size();
`else
        exp_frag = 0;
`endif
        obs_cand = 0;
        obs_pix = 0;
        outstanding = 1;
      end
    end
  end

  task automatic send(input tri_t t);
    int n;
    tri_in = t;
    tri_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (tri_ready) break;
      n++;
      if (n > 3000) begin
        bad("accept_timeout", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((outstanding || !tri_ready) && n < 5000);
    if (n >= 5000) bad("idle_timeout", n);
    repeat (2) @(negedge clk);
  endtask

  function automatic tri_t mk(input int ax, input int ay, input int bx, input int by,
                              input int cx, input int cy);
    tri_t t;
    t[0][0] = 12'(ax); t[0][1] = 12'(ay);
    t[1][0] = 12'(bx); t[1][1] = 12'(by);
    t[2][0] = 12'(cx); t[2][1] = 12'(cy);
    return t;
  endfunction

  initial begin
    tri_t t1, t_off, t_clip, t_new, tr;
    int xb, yb;
    t1     = mk(10, 10, 20, 10, 10, 20);
    t_off  = mk(1300, 5, 1400, 5, 1350, 50);
    t_clip = mk(1275, 715, 1290, 715, 1275, 730);
    t_new  = mk(30, 40, 35, 40, 30, 45);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tri_ready", tri_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_fill_valid", fill_valid_out, 0);
    chk("rst_frag", frag_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send(t1);
    wait_idle();
    chk("t1_cands", obs_cand, 121);
    chk("t1_first", first_c, {12'd10, 12'd10});
    chk("t1_last", last_c, {12'd20, 12'd20});
    chk("t1_pix", obs_pix, 66);

    send(t_off);
    wait_idle();
    chk("off_cands", obs_cand, 0);
    chk("off_pix", obs_pix, 0);

    send(t_clip);
    wait_idle();
    chk("clip_cands", obs_cand, 25);
    chk("clip_first", first_c, {12'd1275, 12'd715});
    chk("clip_last", last_c, {12'd1279, 12'd719});

    send(t1);
    repeat (20) @(negedge clk);
    send(t_clip);
    wait_idle();
    chk("held_second_cands", obs_cand, 25);

    send(t1);
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pix_valid", pix_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_fill_valid", fill_valid_out, 0);
    chk("midrst_tri_ready", tri_ready, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(t_new);
    wait_idle();
    chk("postrst_first", first_c, {12'd30, 12'd40});
    chk("postrst_cands", obs_cand, 36);

    for (int k = 0; k < 30; k++) begin
      xb = int'($urandom_range(0, 1290));
      yb = int'($urandom_range(0, 725));
      for (int i = 0; i < 3; i++) begin
        tr[i][0] = 12'(xb + int'($urandom_range(0, 12)));
        tr[i][1] = 12'(yb + int'($urandom_range(0, 12)));
      end
      send(tr);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
